// File: rtl/iterative_divider_32b.sv
// Multi-cycle radix-2 restoring divider, unsigned or signed (truncating toward zero).
// One quotient bit per cycle; divide-by-zero and signed overflow finish in a single cycle.
module iterative_divider_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  localparam int                CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             bypass_q, bypass_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   trial;

  // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // Partial remainder stays below the divisor, so the shifted value minus divisor fits in WIDTH bits when non-negative.
  assign trial = {rem_acc_q, dvd_q[WIDTH-1]} - {1'b0, dmag_q};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_acc_d   = rem_acc_q;
    dvd_d       = dvd_q;
    dmag_d      = dmag_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    bypass_d    = bypass_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          busy_d    = 1'b1;
          cnt_d     = '0;
          rem_acc_d = '0;
          dvd_d     = a_mag;
          dmag_d    = b_mag;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bypass_d  = 1'b0;
          dz_d      = 1'b0;
          state_d   = CALC;
          if (divisor == '0) begin
            bypass_d  = 1'b1;
            dz_d      = 1'b1;
            dvd_d     = '1;
            rem_acc_d = dividend;
            state_d   = FIX;
          end else if (signed_op && dividend == MIN_NEG && divisor == '1) begin
            bypass_d  = 1'b1;
            dvd_d     = MIN_NEG;
            rem_acc_d = '0;
            state_d   = FIX;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_acc_d = trial[WIDTH-1:0];
          dvd_d     = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_acc_d = {rem_acc_q[WIDTH-2:0], dvd_q[WIDTH-1]};
          dvd_d     = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end

      FIX: begin
        quotient_d  = (!bypass_q && neg_quo_q) ? -dvd_q     : dvd_q;
        remainder_d = (!bypass_q && neg_rem_q) ? -rem_acc_q : rem_acc_q;
        dbz_d       = dz_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_acc_q   <= '0;
      dvd_q       <= '0;
      dmag_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      bypass_q    <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_acc_q   <= rem_acc_d;
      dvd_q       <= dvd_d;
      dmag_q      <= dmag_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      bypass_q    <= bypass_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider_32b.sv
// Self-checking bench for iterative_divider_32b: directed cases, then random operands
// compared against a plain-arithmetic reference model.
module tb_iterative_divider_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_divider_32b #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; 64-bit signed arithmetic truncates toward zero.
  task automatic ref_div(input bit so, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat);
    longint sa, sb, q64, r64;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
    end else begin
      dz = 1'b0;
      if (so) begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        q64 = sa / sb;
        r64 = sa % sb;
        q   = q64[31:0];
        r   = r64[31:0];
      end else begin
        q = a / b;
        r = a % b;
      end
      lat = (so && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : 33;
    end
  endtask

  // Drive a request now; the next rising edge is the acceptance edge.
  task automatic start_op(input bit so, input logic [31:0] a, input logic [31:0] b);
    signed_op = so;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Count edges until done is seen; busy must stay high until then.
  task automatic wait_done(input int bound, input bit chk_busy, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (chk_busy) check("busy_in_flight", busy, 1'b1);
    end
    if (lat < 0) check("done_timeout", done, 1'b1);
  endtask

  task automatic run_op(input string tag, input bit so, input logic [31:0] a, input logic [31:0] b,
                        input bit chk_busy);
    logic [31:0] eq, er;
    logic        edz;
    int          elat, lat;
    ref_div(so, a, b, eq, er, edz, elat);
    @(negedge clk);
    start_op(so, a, b);
    wait_done(60, chk_busy, lat);
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, edz);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int          lat;
    bit          so;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quo", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned and signed cases
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b1);
    check("u100_7_q14", quotient, 32'd14);
    check("u100_7_r2", remainder, 32'd2);
    run_op("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
    check("sm100_7_q", quotient, 32'hFFFF_FFF2);
    check("sm100_7_r", remainder, 32'hFFFF_FFFE);
    run_op("s100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1);
    check("s100_m7_q", quotient, 32'hFFFF_FFF2);
    check("s100_m7_r", remainder, 32'd2);

    // Shortcuts: divide by zero and signed overflow
    run_op("dz_u", 1'b0, 32'h1234_5678, 32'd0, 1'b1);
    check("dz_u_q", quotient, 32'hFFFF_FFFF);
    run_op("dz_s", 1'b1, 32'h1234_5678, 32'd0, 1'b1);
    check("dz_s_r", remainder, 32'h1234_5678);
    run_op("ovf_s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("ovf_s_q", quotient, 32'h8000_0000);
    run_op("ovf_u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("ovf_u_r", remainder, 32'h8000_0000);

    // start while busy is ignored
    @(negedge clk);
    start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(60, 1'b1, lat);
    check("busy_ign_lat", lat, 29);
    check("busy_ign_q", quotient, 32'hFFFF_FFFF);
    check("busy_ign_r", remainder, 32'd0);

    // start on the done cycle is accepted; old results stay visible meanwhile
    start_op(1'b0, 32'd50, 32'd5);
    check("done_start_done_low", done, 1'b0);
    check("done_start_busy", busy, 1'b1);
    check("done_start_old_q", quotient, 32'hFFFF_FFFF);
    wait_done(60, 1'b1, lat);
    check("done_start_lat", lat, 33);
    check("done_start_q", quotient, 32'd10);
    check("done_start_r", remainder, 32'd0);

    // Reset mid-operation
    @(negedge clk);
    start_op(1'b0, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_quo", quotient, 32'd0);
    check("abort_rem", remainder, 32'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_dbz", div_by_zero, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", done, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("post_rst_no_done", done, 1'b0);
    end
    run_op("after_rst", 1'b0, 32'd9, 32'd3, 1'b1);
    check("after_rst_q", quotient, 32'd3);

    // Random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      so = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3, 4: b = 32'($urandom_range(1, 255));
        5:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 19) == 0) a = 32'h8000_0000;
      run_op(so ? "rand_s" : "rand_u", so, a, b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
